regfile_dump_streamer: RTL and testbench

Hardware counterpart of the bench register checker: runs the processor for a programmed number of cycles, then takes over the register file's port-A read select. It sweeps the registers in order and streams each one out as a (register index, value) record over a valid/ready handshake. It sits beside `processor` and `regfile`. The `rd_sel`/`test_mode` pair drives the port-A read-select mux in front of `regfile`, and the record stream feeds a UART or trace sink on silicon runs.

---
 rtl/regfile_dump_streamer_if.sv | 11 +
 rtl/regfile_dump_streamer.sv | 122 ++++++++++++
 tb/tb_regfile_dump_streamer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_streamer_if.sv
// Record stream between regfile_dump_streamer and its trace/UART sink.
// One record = (register index, register value), valid/ready handshake.
interface regfile_dump_streamer_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_reg;
    logic [31:0] out_value;

    modport master (output out_valid, output out_reg, output out_value, input out_ready);
    modport slave  (input out_valid, input out_reg, input out_value, output out_ready);
endinterface

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: runs the processor for num_cycles, then takes over the
// regfile port-A read select and streams every register out as (index, value).
// Optional feature: define REGDUMP_SKIP_ZERO_EN to drop zero-valued registers
// from the stream (CAPTURE goes straight to the next SELECT or to DONE).
module regfile_dump_streamer #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_cycles,
    output logic                 cpu_run,
    output logic                 test_mode,
    output logic [4:0]           rd_sel,
    input  logic [31:0]          rd_data,
    output logic                 busy,
    output logic                 done,
    regfile_dump_streamer_if.master out_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_SELECT, S_CAPTURE, S_SEND, S_DONE
    } state_t;

    localparam logic [4:0] IDX_LAST = 5'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         idx_q, idx_d;
    logic [4:0]         reg_q, reg_d;
    logic [31:0]        val_q, val_d;

    // State and datapath registers; async active-low reset drops everything to IDLE/0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
        end
    end

    // Next-state logic: run countdown, then SELECT/CAPTURE/SEND per register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        reg_d   = reg_q;
        val_d   = val_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d   = num_cycles;
                    idx_d   = '0;
                    state_d = (num_cycles == '0) ? S_SELECT : S_RUN;
                end
            end
            S_RUN: begin
                // Entered only with a nonzero count, so cnt_q never wraps here.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_SELECT;
            end
            S_SELECT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                // rd_sel has been stable for a full cycle, so rd_data is settled.
`ifdef REGDUMP_SKIP_ZERO_EN
                if (rd_data == 32'd0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_SELECT;
                    end
                end else begin
                    reg_d   = idx_q;
                    val_d   = rd_data;
                    state_d = S_SEND;
                end
`else
                reg_d   = idx_q;
                val_d   = rd_data;
                state_d = S_SEND;
`endif
            end
            S_SEND: begin
                if (out_if.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_SELECT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset forces them all to 0.
    always_comb begin
        cpu_run          = (state_q == S_RUN);
        test_mode        = (state_q == S_SELECT) || (state_q == S_CAPTURE) ||
                           (state_q == S_SEND)   || (state_q == S_DONE);
        busy             = (state_q == S_RUN)    || (state_q == S_SELECT) ||
                           (state_q == S_CAPTURE) || (state_q == S_SEND);
        done             = (state_q == S_DONE);
        rd_sel           = ((state_q == S_SELECT) || (state_q == S_CAPTURE) ||
                            (state_q == S_SEND)) ? idx_q : 5'd0;
        out_if.out_valid = (state_q == S_SEND);
        out_if.out_reg   = reg_q;
        out_if.out_value = val_q;
    end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Bench for regfile_dump_streamer: a behavioural regfile array answers rd_sel,
// and each sweep is checked against an expected record list and cycle timeline
// derived from the register contents and run length.
module tb_regfile_dump_streamer;

    localparam int NUM_REGS = 32;
    localparam int CNT_W    = 10;
    localparam int BUDGET   = 3000;
`ifdef REGDUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_cycles;
    logic             cpu_run, test_mode, busy, done;
    logic [4:0]       rd_sel;
    logic [31:0]      rd_data;
    logic [31:0]      rf [0:NUM_REGS-1];

    int checks = 0;
    int errors = 0;

    regfile_dump_streamer_if bus ();

    regfile_dump_streamer #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_cycles (num_cycles),
        .cpu_run    (cpu_run),
        .test_mode  (test_mode),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .out_if     (bus)
    );

    assign rd_data = rf[rd_sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready tied high; 1: random ready; 2: hold ready low 7 cycles on r4.
    // pulse_reg: pulse start while that record is offered; abort_reg: reset there.
    task automatic run_sweep(input int n, input int mode, input int pulse_reg, input int abort_reg);
        int          exp_reg[$];
        logic [31:0] exp_val[$];
        int          t, cpu_cnt, s_cycles, first_emit, stall_n;
        bit          seen_valid, stalled, pulsed, finished, rdy;
        logic [4:0]  prev_reg;
        logic [31:0] prev_val;
        s_cycles = 0; first_emit = -1; cpu_cnt = 0; stall_n = 0;
        seen_valid = 0; stalled = 0; pulsed = 0; finished = 0;
        prev_reg = '0; prev_val = '0;
        // Expected stream: every register in order, zero ones dropped when skipping.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (SKIP && rf[i] == 32'd0) begin
                s_cycles += 2;
            end else begin
                if (first_emit < 0) first_emit = i;
                exp_reg.push_back(i);
                exp_val.push_back(rf[i]);
                s_cycles += 3;
            end
        end
        if (first_emit < 0) first_emit = 0;

        @(negedge clock);
        start = 1'b1;
        num_cycles = n[CNT_W-1:0];
        bus.out_ready = (mode == 0);
        @(negedge clock);
        start = 1'b0;
        t = 1;
        while (!finished && t <= BUDGET) begin
            chk("cpu_run", cpu_run, (t <= n));
            if (cpu_run) cpu_cnt++;
            if (t == 1) chk("done_cleared", done, 0);
            if (t <= n) chk("test_mode_run", test_mode, 0);
            else if (!done) chk("test_mode_sweep", test_mode, 1);
            if (!done) chk("busy", busy, 1);
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_test_mode", test_mode, 1);
                if (mode == 0) chk("done_time", t, n + 1 + s_cycles);
                chk("records_left", exp_reg.size(), 0);
                finished = 1;
            end else if (bus.out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    chk("first_valid_time", t, n + 3 + 2 * first_emit);
                end
                chk("rd_sel_send", rd_sel, bus.out_reg);
                if (stalled) begin
                    chk("stall_reg", bus.out_reg, prev_reg);
                    chk("stall_val", bus.out_value, prev_val);
                end
                if (abort_reg == int'(bus.out_reg)) begin
                    reset = 1'b0;
                    #1;
                    chk("abort_outputs", {cpu_run, test_mode, rd_sel, bus.out_valid,
                                          bus.out_reg, bus.out_value, busy, done}, 0);
                    @(negedge clock);
                    reset = 1'b1;
                    @(negedge clock);
                    chk("abort_idle", {busy, done, test_mode, cpu_run, bus.out_valid}, 0);
                    return;
                end
                if (pulse_reg == int'(bus.out_reg) && !pulsed) begin
                    start = 1'b1;
                    num_cycles = CNT_W'(7);
                    pulsed = 1;
                end
                case (mode)
                    0: rdy = 1;
                    1: rdy = 1'($urandom_range(0, 1));
                    default: begin
                        if (bus.out_reg == 5'd4 && stall_n < 7) begin
                            rdy = 0;
                            stall_n++;
                        end else begin
                            rdy = 1;
                        end
                    end
                endcase
                bus.out_ready = rdy;
                if (rdy) begin
                    if (exp_reg.size() == 0) begin
                        chk("extra_record", 1, 0);
                    end else begin
                        chk("rec_reg", bus.out_reg, exp_reg.pop_front());
                        chk("rec_val", bus.out_value, exp_val.pop_front());
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev_reg = bus.out_reg;
                    prev_val = bus.out_value;
                end
            end else begin
                stalled = 0;
                bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
            end
            if (!finished) begin
                @(negedge clock);
                start = 1'b0;
                t++;
            end
        end
        if (!finished) chk("sweep_timeout", 0, 1);
        else chk("cpu_run_cycles", cpu_cnt, n);
        if (mode == 2) chk("stall_cycles", stall_n, 7);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        num_cycles = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'(i * 3);

        repeat (3) @(negedge clock);
        chk("reset_outputs", {cpu_run, test_mode, rd_sel, bus.out_valid, bus.out_reg,
                              bus.out_value, busy, done}, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", {cpu_run, test_mode, busy, done, bus.out_valid}, 0);

        // rN = 3N, five run cycles, sink always ready.
        run_sweep(5, 0, -1, -1);
        // Zero-length run, started from DONE.
        run_sweep(0, 0, -1, -1);
        // Backpressure on r4.
        rf[4] = 32'hDEADBEEF;
        rf[5] = $urandom;
        run_sweep(3, 2, -1, -1);
        // start pulsed mid-sweep at r10 is ignored.
        run_sweep(2, 0, 10, -1);
        // Reset during SEND of r12.
        run_sweep(4, 0, -1, 12);
        // Randomised register contents, run lengths and sink readiness.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_sweep(int'($urandom_range(0, 12)), 1, -1, -1);
        end
        // Only r3 and r20 nonzero, then an all-zero regfile.
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'd0;
        rf[3]  = 32'd7;
        rf[20] = 32'hFFFFFFFF;
        run_sweep(1, 0, -1, -1);
        rf[3]  = 32'd0;
        rf[20] = 32'd0;
        run_sweep(2, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
